mem_match_scanner: RTL

Sequential search engine that sits directly upstream of the 16x32 SRAM. It drives the SRAM read address and consumes the SRAM read bus. On a Start pulse it sweeps every word, compares each word against a latched Key under a latched Mask, and reports match count, first-match address and a per-word hit bitmap, then signals Done. The SRAM read path is asynchronous with a 0.3 ns output delay, so each word is sampled on the clock edge after its address is driven.

---
 rtl/mem_match_pkg.sv | 27 ++
 rtl/mem_match_cmp.sv | 61 ++++++
 rtl/mem_match_scanner.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_match_pkg.sv
// mem_match_pkg
//   Shared types and constants for the SRAM match scanner: the scan FSM
//   state type, the SRAM geometry and the masked-compare helper.
package mem_match_pkg;

    localparam int DEPTH   = 16;          // SRAM words scanned, addresses 0..DEPTH-1
    localparam int ADDR_W  = 4;           // log2(DEPTH)
    localparam int DATA_W  = 32;          // SRAM word width
    localparam int COUNT_W = ADDR_W + 1;  // holds 0..DEPTH inclusive

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } scanStateT;

    // A word matches when every bit selected by the mask equals the key.
    function automatic logic isHit(
        input logic [DATA_W-1:0] data,
        input logic [DATA_W-1:0] key,
        input logic [DATA_W-1:0] mask
    );
        return ((data ^ key) & mask) == '0;
    endfunction

endpackage

// File: rtl/mem_match_cmp.sv
// mem_match_cmp
//   Stage-2 masked comparator and result accumulator. Each valid stage-1
//   entry is compared against the latched key under the latched mask, and a
//   hit updates the bitmap, count, found flag and first-match address.
//
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   clear            clear all results (new scan accepted)
//   valid            stage-1 entry present this cycle
//   data, addr       stage-1 word and the address it was read from
//   key, mask        latched search key and compare mask
//   matchFound       at least one hit this scan
//   matchCount       number of hits, 0..DEPTH
//   firstMatchAddr   address of the first (lowest) hit, 0 if none
//   matchBitmap      bit i set iff word i hit
module mem_match_cmp
    import mem_match_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               valid,
    input  logic [DATA_W-1:0]  data,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [DATA_W-1:0]  key,
    input  logic [DATA_W-1:0]  mask,
    output logic               matchFound,
    output logic [COUNT_W-1:0] matchCount,
    output logic [ADDR_W-1:0]  firstMatchAddr,
    output logic [DEPTH-1:0]   matchBitmap
);

    logic hit;

    assign hit = valid && isHit(data, key, mask);

    // NOTE: the bitmap is a flat flop vector rather than a RAM, so it can and
    // must be cleared by reset along with the other result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            matchFound     <= 1'b0;
            matchCount     <= '0;
            firstMatchAddr <= '0;
            matchBitmap    <= '0;
        end else if (clear) begin
            matchFound     <= 1'b0;
            matchCount     <= '0;
            firstMatchAddr <= '0;
            matchBitmap    <= '0;
        end else if (hit) begin
            matchFound        <= 1'b1;
            matchCount        <= matchCount + COUNT_W'(1);
            matchBitmap[addr] <= 1'b1;
            // Addresses arrive in ascending order, so the first hit is the lowest.
            if (!matchFound) begin
                firstMatchAddr <= addr;
            end
        end
    end

endmodule

// File: rtl/mem_match_scanner.sv
// mem_match_scanner
//   Sequential search engine in front of a 16x32 asynchronous-read SRAM.
//   A Start pulse latches Key/Mask and sweeps every address; each word is
//   sampled on the edge after its address is driven (stage 1) and compared
//   one cycle later (stage 2). Done pulses once when results are final.
//
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   Start            scan request, accepted only in IDLE or DONE
//   Key, Mask        search value and compare mask (1 = bit participates)
//   ReadAddress      registered SRAM read address
//   ReadBus          SRAM read data for ReadAddress
//   Busy             high in SCAN and DRAIN
//   Done             one-cycle pulse when results are final
//   MatchFound       at least one word matched
//   MatchCount       number of matching words, 0..DEPTH
//   FirstMatchAddr   lowest matching address, 0 if none
//   MatchBitmap      bit i set iff word i matched
module mem_match_scanner
    import mem_match_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               Start,
    input  logic [DATA_W-1:0]  Key,
    input  logic [DATA_W-1:0]  Mask,
    output logic [ADDR_W-1:0]  ReadAddress,
    input  logic [DATA_W-1:0]  ReadBus,
    output logic               Busy,
    output logic               Done,
    output logic               MatchFound,
    output logic [COUNT_W-1:0] MatchCount,
    output logic [ADDR_W-1:0]  FirstMatchAddr,
    output logic [DEPTH-1:0]   MatchBitmap
);

    scanStateT         state;
    scanStateT         nextState;
    logic              startAccept;
    logic              lastAddr;

    logic [DATA_W-1:0] keyQ;
    logic [DATA_W-1:0] maskQ;
    logic [DATA_W-1:0] dataQ;
    logic [ADDR_W-1:0] addrQ;
    logic              validQ;

    // Start is only honoured when no scan is in flight; DONE counts as idle
    // so scans can run back to back.
    assign startAccept = Start && (state == IDLE || state == DONE);
    assign lastAddr    = (ReadAddress == ADDR_W'(DEPTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: nextState gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (startAccept) nextState = SCAN;
            SCAN:    if (lastAddr)    nextState = DRAIN;
            DRAIN:                    nextState = DONE;
            DONE:    nextState = startAccept ? SCAN : IDLE;
            default:                  nextState = IDLE;
        endcase
    end

    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state)
            SCAN, DRAIN: Busy = 1'b1;
            DONE:        Done = 1'b1;
            default:     ;
        endcase
    end

    // Address counter, key/mask latches and stage-1 capture. ReadAddress only
    // moves on edges, giving the SRAM almost a full cycle to settle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ReadAddress <= '0;
            keyQ        <= '0;
            maskQ       <= '0;
            dataQ       <= '0;
            addrQ       <= '0;
            validQ      <= 1'b0;
        end else if (startAccept) begin
            ReadAddress <= '0;
            keyQ        <= Key;
            maskQ       <= Mask;
            validQ      <= 1'b0;
        end else if (state == SCAN) begin
            dataQ       <= ReadBus;
            addrQ       <= ReadAddress;
            validQ      <= 1'b1;
            ReadAddress <= lastAddr ? '0 : ReadAddress + ADDR_W'(1);
        end else begin
            validQ      <= 1'b0;
        end
    end

    mem_match_cmp uCmp (
        .clock          (clock),
        .reset_n        (reset_n),
        .clear          (startAccept),
        .valid          (validQ),
        .data           (dataQ),
        .addr           (addrQ),
        .key            (keyQ),
        .mask           (maskQ),
        .matchFound     (MatchFound),
        .matchCount     (MatchCount),
        .firstMatchAddr (FirstMatchAddr),
        .matchBitmap    (MatchBitmap)
    );

endmodule
